// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle RV32-style instruction control FSM
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset, forces FETCH
//   opcode[6:0]   instruction opcode, frozen after FETCH
//   mem_ready     memory handshake, access completes when high
//   branch_taken  ALU branch compare result, used in EXECUTE
//   ir_write      load instruction register
//   pc_write      update PC
//   pc_src        0 = PC+4, 1 = ALU target
//   mem_read      memory read request
//   mem_write     memory write request
//   mem_addr_sel  0 = PC, 1 = ALU result
//   reg_write     register-file write enable
//   wb_sel[1:0]   0 = ALU, 1 = memory data, 2 = PC+4
//   state[2:0]    FETCH=0 DECODE=1 EXECUTE=2 MEM=3 WB=4 TRAP=5
//   retire        one-cycle pulse per completed instruction
//   illegal       high while in TRAP
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_addr_sel,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [2:0] state,
  output logic       retire,
  output logic       illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  state_t cur_state;
  state_t nxt_state;

  logic is_load;
  logic is_store;
  logic is_branch;
  logic is_jump;
  logic is_legal;

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign is_legal  = is_load || is_store || is_branch || is_jump ||
                     (opcode == OP_R) || (opcode == OP_I) ||
                     (opcode == OP_LUI) || (opcode == OP_AUIPC);

  assign state = cur_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state    = cur_state;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    retire       = 1'b0;
    illegal      = 1'b0;

    case (cur_state)
      S_FETCH: begin
        mem_read = 1'b1;
        // Reset holds the FSM in FETCH; keep ir_write quiet so the
        // instruction register is not loaded while reset is asserted.
        ir_write = mem_ready && !rst;
        if (mem_ready) begin
          nxt_state = S_DECODE;
        end
      end
      S_DECODE: begin
        nxt_state = is_legal ? S_EXECUTE : S_TRAP;
      end
      S_EXECUTE: begin
        if (is_load || is_store) begin
          nxt_state = S_MEM;
        end else if (is_branch) begin
          pc_write  = 1'b1;
          pc_src    = branch_taken;
          retire    = 1'b1;
          nxt_state = S_FETCH;
        end else begin
          nxt_state = S_WB;
        end
      end
      S_MEM: begin
        // Only LOAD or STORE reach MEM, and opcode is frozen here.
        mem_addr_sel = 1'b1;
        mem_write    = is_store;
        mem_read     = !is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_write  = 1'b1;
            retire    = 1'b1;
            nxt_state = S_FETCH;
          end else begin
            nxt_state = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        pc_src    = is_jump;
        wb_sel    = is_load ? 2'd1 : (is_jump ? 2'd2 : 2'd0);
        nxt_state = S_FETCH;
      end
      S_TRAP: begin
        illegal   = 1'b1;
        nxt_state = S_TRAP;
      end
      default: begin
        nxt_state = S_FETCH;
      end
    endcase
  end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 SHALL have exactly one clock `clk`; reset `rst` is asynchronous and active-high.
REQ-002 Port `clk`  in  1  system clock, all state updates on rising edge.
REQ-003 Port `rst`  in  1  async active-high reset.
REQ-004 Port `opcode`  in  7  opcode field from instruction register, stable from DECODE until the next FETCH.
REQ-005 Port `mem_ready`  in  1  memory handshake, access completes in a cycle where it is high.
REQ-006 Port `branch_taken`  in  1  ALU branch compare result, sampled in EXECUTE.
REQ-007 Port `ir_write`  out  1  load instruction register.
REQ-008 Port `pc_write`  out  1  update PC.
REQ-009 Port `pc_src`  out  1  next-PC select: 0 = PC+4, 1 = ALU target.
REQ-010 Port `mem_read`  out  1  memory read request.
REQ-011 Port `mem_write`  out  1  memory write request.
REQ-012 Port `mem_addr_sel`  out  1  memory address select: 0 = PC, 1 = ALU result.
REQ-013 Port `reg_write`  out  1  register-file write enable.
REQ-014 Port `wb_sel`  out  2  writeback source: 0 = ALU, 1 = memory data, 2 = PC+4; 3 is never driven.
REQ-015 Port `state`  out  3  current state encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5.
REQ-016 Port `retire`  out  1  one-cycle pulse per completed instruction.
REQ-017 Port `illegal`  out  1  high while in TRAP.

Function
REQ-018 Recognised opcodes: R=0110011, I=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011, JAL=1101111, JALR=1100111, LUI=0110111, AUIPC=0010111; any other value is illegal.
REQ-019 All outputs are combinational from `state`, `opcode`, `mem_ready` and `branch_taken`; any output not named for a state is 0.
REQ-020 FETCH: drive `mem_read`=1 and `mem_addr_sel`=0.
- `mem_ready`=1: drive `ir_write`=1 and go to DECODE.
- `mem_ready`=0: stay in FETCH for as many wait cycles as memory takes.
REQ-021 DECODE: drive no enables; an illegal opcode goes to TRAP, otherwise go to EXECUTE.
REQ-022 EXECUTE:
- LOAD/STORE: go to MEM.
- BRANCH: drive `pc_write`=1, `pc_src`=`branch_taken`, `retire`=1, and go to FETCH.
- All other opcodes: go to WB.
REQ-023 MEM, LOAD: drive `mem_read`=1 and `mem_addr_sel`=1; hold until `mem_ready`=1, then go to WB.
REQ-024 MEM, STORE: drive `mem_write`=1 and `mem_addr_sel`=1; hold until `mem_ready`=1. In that cycle also drive `pc_write`=1, `pc_src`=0, `retire`=1, and go to FETCH.
REQ-025 WB: drive `reg_write`=1, `pc_write`=1, `retire`=1, then go to FETCH.
- `wb_sel`: 1 for LOAD, 2 for JAL/JALR, otherwise 0.
- `pc_src`: 1 for JAL/JALR, otherwise 0.
REQ-026 TRAP: drive `illegal`=1 with all enables 0; TRAP is sticky and only reset exits it.
REQ-027 `mem_ready` SHALL be ignored in DECODE, EXECUTE, WB and TRAP.
REQ-028 `mem_read` and `mem_write` SHALL never be high in the same cycle.
REQ-029 `ir_write` SHALL be asserted only in FETCH, so `opcode` is frozen for the rest of the instruction.
REQ-030 Latency with zero memory wait cycles, in cycles:

| Class | Cycles |
|---|---|
| BRANCH | 3 |
| STORE | 4 |
| R / I / LUI / AUIPC / JAL / JALR | 4 |
| LOAD | 5 |

Each memory wait cycle adds one cycle.

Reset
REQ-031 `rst`=1 SHALL force `state` to FETCH immediately, without waiting for a clock edge, including mid-MEM or in TRAP.
REQ-032 During reset, all outputs except the FETCH values `mem_read`=1 and `mem_addr_sel`=0 SHALL read 0.
REQ-033 The first `clk` edge after `rst` deasserts SHALL be evaluated as a normal FETCH cycle.

Verification
REQ-034 R-type 0110011, `mem_ready` tied 1 -> `state` sequence 0,1,2,4,0; `reg_write`=1 and `retire`=1 only in WB; `wb_sel`=0.
REQ-035 LOAD with `mem_ready` low for 2 cycles in both FETCH and MEM -> FETCH held 3 cycles and MEM held 3 cycles; `wb_sel`=1 in WB; total 9 cycles.
REQ-036 BRANCH with `branch_taken`=1, then BRANCH with `branch_taken`=0 -> EXECUTE shows `pc_write`=1 with `pc_src`=1, then `pc_src`=0; no `reg_write` in either.
REQ-037 STORE -> MEM shows `mem_write`=1 and `mem_addr_sel`=1; `retire` pulses in the `mem_ready` cycle; WB never entered.
REQ-038 `opcode`=1111111 -> DECODE then TRAP; `illegal`=1 held for 20 cycles despite `mem_ready` toggling; `rst` pulse returns `state` to 0.
REQ-039 `rst` asserted mid-MEM of a LOAD, between clock edges -> `state`=0 before the next edge; no `reg_write` pulse occurs.
